// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive-side time-division 1-to-4 demultiplexer.
//
// A single sample stream carries four channels in fixed slot order
// (slot 0..3 = channel a..d). A frame_sync strobe on a valid sample marks
// slot 0. Samples for slots 0..2 are parked in shadow registers. The slot-3
// sample completes the frame: all four channels load into y0..y3 together
// and frame_valid pulses for one cycle. y0..y3 therefore never show a
// partial frame.
//
// Parameters:
//   WIDTH       - bits per sample / per channel output
//   SYNC_STRICT - 1: a slot-0 sample without frame_sync is a framing error
//                    and drops the block back to HUNT
//                 0: such a sample is accepted as slot 0
//
// Optional feature (macro TDM_DEMUX_ERR_CNT_EN):
//   Adds output err_cnt[7:0], a saturating count of sync_err pulses that is
//   cleared only by rst_n. With the macro undefined, the port and the
//   counter do not exist.
//
// FSM states:
//   state  | meaning
//   -------+--------------------------------------------------------------
//   HUNT   | not aligned; discard samples until one arrives with frame_sync
//   LOCKED | aligned; slot_q is the slot that the next valid sample fills

module tdm_demux_1x4 #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STRICT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             sync_err,
`ifdef TDM_DEMUX_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             locked
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_nxt;
    logic [1:0]       slot_q, slot_nxt;
    logic [WIDTH-1:0] shadow0_q, shadow0_nxt;
    logic [WIDTH-1:0] shadow1_q, shadow1_nxt;
    logic [WIDTH-1:0] shadow2_q, shadow2_nxt;
    logic [WIDTH-1:0] y0_q, y0_nxt;
    logic [WIDTH-1:0] y1_q, y1_nxt;
    logic [WIDTH-1:0] y2_q, y2_nxt;
    logic [WIDTH-1:0] y3_q, y3_nxt;
    logic             frame_valid_q, frame_valid_nxt;
    logic             sync_err_q, sync_err_nxt;

    // Decoded framing conditions for a valid sample in LOCKED.
    logic             resync_hit;
    logic             missing_sync;

    assign resync_hit   = frame_sync && (slot_q != 2'd0);
    assign missing_sync = !frame_sync && (slot_q == 2'd0) && (SYNC_STRICT != 0);

    // State, slot, shadow and output registers; async clear on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            y3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            slot_q        <= slot_nxt;
            shadow0_q     <= shadow0_nxt;
            shadow1_q     <= shadow1_nxt;
            shadow2_q     <= shadow2_nxt;
            y0_q          <= y0_nxt;
            y1_q          <= y1_nxt;
            y2_q          <= y2_nxt;
            y3_q          <= y3_nxt;
            frame_valid_q <= frame_valid_nxt;
            sync_err_q    <= sync_err_nxt;
        end
    end

    // Next-state, slot tracking and frame assembly; everything holds on
    // din_valid=0 and the two pulses fall back to 0.
    always_comb begin
        state_nxt       = state_q;
        slot_nxt        = slot_q;
        shadow0_nxt     = shadow0_q;
        shadow1_nxt     = shadow1_q;
        shadow2_nxt     = shadow2_q;
        y0_nxt          = y0_q;
        y1_nxt          = y1_q;
        y2_nxt          = y2_q;
        y3_nxt          = y3_q;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow0_nxt = din;
                        slot_nxt    = 2'd1;
                        state_nxt   = LOCKED;
                    end
                end

                LOCKED: begin
                    if (resync_hit) begin
                        // Early sync: drop the partial frame and restart at
                        // this sample as slot 0.
                        sync_err_nxt = 1'b1;
                        shadow0_nxt  = din;
                        slot_nxt     = 2'd1;
                    end else if (missing_sync) begin
                        // Expected a sync that never came: lose lock.
                        sync_err_nxt = 1'b1;
                        slot_nxt     = 2'd0;
                        state_nxt    = HUNT;
                    end else begin
                        case (slot_q)
                            2'd0: shadow0_nxt = din;
                            2'd1: shadow1_nxt = din;
                            2'd2: shadow2_nxt = din;
                            default: begin
                                // Slot 3 is taken straight from din, so the
                                // full frame is published in one edge.
                                y0_nxt          = shadow0_q;
                                y1_nxt          = shadow1_q;
                                y2_nxt          = shadow2_q;
                                y3_nxt          = din;
                                frame_valid_nxt = 1'b1;
                            end
                        endcase
                        slot_nxt = slot_q + 2'd1;
                    end
                end

                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = 2'd0;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of framing errors, counted on the same edge that
    // raises sync_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (sync_err_nxt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4. Two instances share the stimulus: index 0 is
// built with SYNC_STRICT=1 and index 1 with SYNC_STRICT=0. A frame-level
// reference model (a list of samples collected for the current frame)
// predicts the outputs of each instance after every clock.
module tb_tdm_demux_1x4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;

    logic [W-1:0] y0_o [2];
    logic [W-1:0] y1_o [2];
    logic [W-1:0] y2_o [2];
    logic [W-1:0] y3_o [2];
    logic         fv_o [2];
    logic         err_o [2];
    logic         lock_o [2];
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]   ec_o [2];
`endif

    int n_vec;
    int n_err;

    // reference model state per instance
    bit           m_locked [2];
    int           m_n [2];
    logic [W-1:0] m_buf [2][4];
    logic [W-1:0] m_y [2][4];
    bit           m_fv [2];
    bit           m_err [2];
    int           m_ec [2];

    tdm_demux_1x4 #(.WIDTH(W), .SYNC_STRICT(1)) u_dut_strict (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y0         (y0_o[0]),
        .y1         (y1_o[0]),
        .y2         (y2_o[0]),
        .y3         (y3_o[0]),
        .frame_valid(fv_o[0]),
        .sync_err   (err_o[0]),
`ifdef TDM_DEMUX_ERR_CNT_EN
        .err_cnt    (ec_o[0]),
`endif
        .locked     (lock_o[0])
    );

    tdm_demux_1x4 #(.WIDTH(W), .SYNC_STRICT(0)) u_dut_loose (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y0         (y0_o[1]),
        .y1         (y1_o[1]),
        .y2         (y2_o[1]),
        .y3         (y3_o[1]),
        .frame_valid(fv_o[1]),
        .sync_err   (err_o[1]),
`ifdef TDM_DEMUX_ERR_CNT_EN
        .err_cnt    (ec_o[1]),
`endif
        .locked     (lock_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_locked[i] = 1'b0;
            m_n[i]      = 0;
            m_fv[i]     = 1'b0;
            m_err[i]    = 1'b0;
            m_ec[i]     = 0;
            for (int k = 0; k < 4; k++) begin
                m_buf[i][k] = '0;
                m_y[i][k]   = '0;
            end
        end
    endtask

    // Frame-level rules: collect samples into a frame list; publish when
    // four are collected; a sync inside a frame or a missing sync at a frame
    // start (strict only) is an error.
    task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
        for (int i = 0; i < 2; i++) begin
            m_fv[i]  = 1'b0;
            m_err[i] = 1'b0;
            if (v) begin
                if (!m_locked[i]) begin
                    if (fs) begin
                        m_locked[i] = 1'b1;
                        m_buf[i][0] = d;
                        m_n[i]      = 1;
                    end
                end else if (fs && m_n[i] != 0) begin
                    m_err[i]    = 1'b1;
                    m_buf[i][0] = d;
                    m_n[i]      = 1;
                end else if (!fs && m_n[i] == 0 && i == 0) begin
                    m_err[i]    = 1'b1;
                    m_locked[i] = 1'b0;
                end else begin
                    m_buf[i][m_n[i]] = d;
                    m_n[i]++;
                    if (m_n[i] == 4) begin
                        for (int k = 0; k < 4; k++) m_y[i][k] = m_buf[i][k];
                        m_fv[i] = 1'b1;
                        m_n[i]  = 0;
                    end
                end
                if (m_err[i] && m_ec[i] < 255) m_ec[i]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_i%0d_y0", tag, i), 32'(y0_o[i]), 32'(m_y[i][0]));
            chk($sformatf("%s_i%0d_y1", tag, i), 32'(y1_o[i]), 32'(m_y[i][1]));
            chk($sformatf("%s_i%0d_y2", tag, i), 32'(y2_o[i]), 32'(m_y[i][2]));
            chk($sformatf("%s_i%0d_y3", tag, i), 32'(y3_o[i]), 32'(m_y[i][3]));
            chk($sformatf("%s_i%0d_fv", tag, i), 32'(fv_o[i]), 32'(m_fv[i]));
            chk($sformatf("%s_i%0d_err", tag, i), 32'(err_o[i]), 32'(m_err[i]));
            chk($sformatf("%s_i%0d_lock", tag, i), 32'(lock_o[i]), 32'(m_locked[i]));
`ifdef TDM_DEMUX_ERR_CNT_EN
            chk($sformatf("%s_i%0d_ecnt", tag, i), 32'(ec_o[i]), 32'(m_ec[i]));
`endif
        end
    endtask

    // Drive one cycle at the falling edge, clock it, check at the next
    // falling edge.
    task automatic cycle(input string tag, input bit v, input bit fs, input logic [W-1:0] d);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model_step(v, fs, d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic sample(input string tag, input bit fs, input logic [W-1:0] d);
        cycle(tag, 1'b1, fs, d);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, '0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        idle("post_reset", 2);

        // first frame 1,0,0,0
        sample("f1_s0", 1'b1, 4'd1);
        sample("f1_s1", 1'b0, 4'd0);
        sample("f1_s2", 1'b0, 4'd0);
        sample("f1_s3", 1'b0, 4'd0);
        chk("f1_fv_seen", 32'(fv_o[0]), 32'd1);
        chk("f1_y0_seen", 32'(y0_o[0]), 32'd1);
        idle("f1_tail", 1);

        // four back-to-back one-hot frames
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 4; s++)
                sample($sformatf("oh_f%0d_s%0d", f, s), s == 0, (s == f) ? 4'd1 : 4'd0);
        chk("oh_last_y3", 32'(y3_o[1]), 32'd1);

        // 3 idle cycles between every sample
        for (int s = 0; s < 4; s++) begin
            sample($sformatf("gap_s%0d", s), s == 0, 4'(s + 5));
            idle("gap_idle", 3);
        end

        // resync on slot 2
        sample("rs_s0", 1'b1, 4'hA);
        sample("rs_s1", 1'b0, 4'hB);
        sample("rs_s2", 1'b1, 4'hC);
        chk("rs_err_seen", 32'(err_o[0]), 32'd1);
        sample("rs_n1", 1'b0, 4'hD);
        sample("rs_n2", 1'b0, 4'hE);
        sample("rs_n3", 1'b0, 4'hF);
        chk("rs_fv_seen", 32'(fv_o[0]), 32'd1);

        // missing sync at the 5th sample
        for (int s = 0; s < 4; s++) sample("ms_frame", s == 0, 4'(s + 1));
        sample("ms_5th", 1'b0, 4'h7);
        chk("ms_strict_err", 32'(err_o[0]), 32'd1);
        chk("ms_strict_unlock", 32'(lock_o[0]), 32'd0);
        for (int s = 0; s < 5; s++) sample("ms_ignored", 1'b0, 4'(s + 8));
        for (int s = 0; s < 4; s++) sample("ms_relock", s == 0, 4'(12 - s));

        // reset after the 2nd sample of a frame
        sample("rm_s0", 1'b1, 4'h3);
        sample("rm_s1", 1'b0, 4'h4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rm_async");
        @(negedge clk);
        rst_n = 1'b1;
        sample("rm_s2", 1'b0, 4'h5);
        sample("rm_s3", 1'b0, 4'h6);
        idle("rm_tail", 1);

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            bit v, fs;
            v  = ($urandom_range(0, 9) < 7);
            fs = ($urandom_range(0, 99) < 20);
            cycle("rnd", v, fs, W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Time-division 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 selector path.
- A single sample stream carries four channels in fixed slot order a,b,c,d (slot 0..3). A frame_sync strobe marks slot 0.
- The block tracks slot position and assembles each frame in shadow registers. It then presents all four channels together on registered outputs with a one-cycle frame_valid pulse.
- It sits between the serial/muxed link and per-channel consumers.

Parameters:
- WIDTH, 1, bit width of each sample and of each channel output.
- SYNC_STRICT, 1, if 1: a slot-0 sample without frame_sync is a sync error. If 0: it is accepted.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  muxed sample stream
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualifies din as slot 0; only sampled when din_valid=1
- y0  output  WIDTH  channel a (slot 0) of last complete frame
- y1  output  WIDTH  channel b (slot 1)
- y2  output  WIDTH  channel c (slot 2)
- y3  output  WIDTH  channel d (slot 3)
- frame_valid  output  1  one-cycle pulse: y0..y3 updated
- sync_err  output  1  one-cycle pulse: framing violation detected
- locked  output  1  state is LOCKED

Behaviour:
- Reset (async assert, sync release):
  - y0..y3 = 0, frame_valid = 0, sync_err = 0, locked = 0.
  - State = HUNT, slot counter = 0, shadow registers = 0.
- All logic advances only on cycles with din_valid=1. On din_valid=0 every register holds and the pulses deassert.
- State HUNT:
  - Samples without frame_sync are discarded.
  - din_valid & frame_sync: store din in shadow0, slot <= 1, go LOCKED.
- State LOCKED, on each valid sample:
  - Normal case: store din in shadow[slot], then slot <= slot+1 (2-bit, wraps 3->0).
  - Slot 3 sample: on the next edge, y0..y3 <= {shadow0, shadow1, shadow2, din} simultaneously and frame_valid = 1 for exactly one cycle. Latency is 1 clock from the slot-3 sample edge.
  - frame_sync with slot != 0: sync_err pulse, partial frame discarded, no frame_valid. The sample is taken as slot 0 (shadow0 <= din, slot <= 1). State remains LOCKED.
  - slot == 0 without frame_sync:
    - SYNC_STRICT=1: sync_err pulse, sample discarded, go HUNT, slot <= 0.
    - SYNC_STRICT=0: accepted as slot 0.
  - frame_sync with slot == 0: normal slot-0 capture.
- Outputs y0..y3 hold their last complete frame until the next frame completes. They never show a partial frame.
- frame_valid and sync_err are never asserted in the same cycle.
- Reset asserted mid-frame: all state clears immediately. No frame_valid is produced for the interrupted frame.

Optional Feature:
- Macro TDM_DEMUX_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt [7:0].
  - Increments on every sync_err pulse and saturates at 255.
  - Cleared only by rst_n.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=1, valid samples 1,0,0,0 with frame_sync on the first -> one cycle after the 4th sample: y0..y3 = 1,0,0,0, frame_valid = 1 for 1 cycle, locked = 1.
- Four back-to-back frames repeating the 4x1 pattern (one-hot at slot 0,1,2,3) -> y = 1000, 0100, 0010, 0001 on successive frame_valid pulses. No sync_err.
- din_valid gaps of 3 idle cycles between each sample of a frame -> same result as contiguous: frame_valid only after the 4th valid sample, and outputs held during gaps.
- frame_sync reasserted on slot 2 -> sync_err pulse, no frame_valid for that frame. The next 3 samples complete a frame starting at the resync sample. With TDM_DEMUX_ERR_CNT_EN defined, err_cnt = 1.
- SYNC_STRICT=1, 5th valid sample without frame_sync -> sync_err, locked = 0. Samples are ignored until the next frame_sync.
- rst_n pulled low after the 2nd sample of a frame -> all outputs 0 immediately. After release, the remaining samples of that frame produce no frame_valid.
